// File: rtl/instr_fetch_if.sv
// Purpose : groups the fetch stage's memory, decode and redirect signals into one bundle.
// Latency : none; this file only declares wires and modports.
// Backpressure: id_ready stalls the decode handoff; the memory side has no stall input.
// Ports   : master = fetch stage (drives imem_req/addr and the id_* outputs);
//           slave  = environment (memory, decode stage, execute-stage redirect).
interface instr_fetch_if;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [31:0] fetch_count;

  modport master (
    input  branch_taken, branch_target, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_pc, id_instr, id_opcode, fetch_count
  );

  modport slave (
    output branch_taken, branch_target, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_pc, id_instr, id_opcode, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Purpose : instruction fetch stage with one outstanding imem read and a branch redirect.
// Latency : request, memory latency, then one HOLD cycle; best case is 3 cycles per instruction.
// Backpressure: id_ready low keeps the word in HOLD and blocks new requests.
// Ports   : clk, reset (synchronous, active high); bus = instr_fetch_if.master
//           (imem request/response, decode valid/ready with pc/instr/opcode, redirect, fetch_count).
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;
  logic [31:0] fetch_count_q;

  logic [31:0] target_d;
  logic [31:0] pc_inc_d;
  logic [31:0] count_inc_d;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign target_d    = {bus.branch_target[31:2], 2'b00};
  assign pc_inc_d    = pc_q + 32'd4;
  assign count_inc_d = fetch_count_q + 32'd1;

  // A request in the same cycle as a redirect would fetch the wrong path, so
  // it is suppressed; reset also masks it because state_q may be stale then.
  assign bus.imem_req    = (state_q == FETCH) && !bus.branch_taken && !reset;
  assign bus.imem_addr   = pc_q;
  // A redirect kills the held word in the same cycle, before decode can take it.
  assign bus.id_valid    = valid_q && !bus.branch_taken;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_opcode   = id_instr_q[6:0];
  assign bus.fetch_count = fetch_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      id_pc_q       <= 32'd0;
      id_instr_q    <= NOP_INSTR;
      fetch_count_q <= 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.branch_taken) begin
            pc_q <= target_d;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.branch_taken) begin
            // The outstanding read must still complete; if it has not yet
            // returned, DRAIN swallows it so it is never mistaken for the
            // redirected fetch.
            pc_q    <= target_d;
            state_q <= bus.imem_rvalid ? FETCH : DRAIN;
          end else if (bus.imem_rvalid) begin
            id_instr_q <= bus.imem_rdata;
            id_pc_q    <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_inc_d;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.branch_taken) begin
            valid_q    <= 1'b0;
            id_instr_q <= NOP_INSTR;
            pc_q       <= target_d;
            state_q    <= FETCH;
          end else if (bus.id_ready) begin
            valid_q       <= 1'b0;
            fetch_count_q <= count_inc_d;
            state_q       <= FETCH;
          end
        end
        DRAIN: begin
          if (bus.branch_taken) begin
            pc_q <= target_d;
          end
          if (bus.imem_rvalid) begin
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose : self-checking bench for instr_fetch with a variable-latency memory model.
// Latency : memory answers lat cycles after each request.
// Backpressure: id_ready is driven per scenario to exercise HOLD.
module tb_instr_fetch;

  logic clk;
  logic reset;
  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  int          lat    = 1;
  logic [31:0] exp_addr_q[$];
  xfer_t       exp_xfer_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0033;
      32'h0000_0004: mem_word = 32'h00A0_0093;
      32'h0000_0008: mem_word = 32'h0020_8133;
      32'h0000_0100: mem_word = 32'h0000_00B3;
      default:       mem_word = {a[31:8], 8'h13};
    endcase
  endfunction

  // Memory model: a request seen at a rising edge returns data lat cycles later.
  initial begin
    logic        s_req, s_rst, pend;
    logic [31:0] s_addr, paddr;
    int          cnt;
    pend = 1'b0;
    paddr = 32'd0;
    cnt = 0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      s_req  = bus.imem_req;
      s_addr = bus.imem_addr;
      s_rst  = reset;
      #1;
      bus.imem_rvalid = 1'b0;
      if (s_rst) begin
        pend = 1'b0;
      end else begin
        if (s_req) begin
          pend  = 1'b1;
          paddr = s_addr;
          cnt   = lat;
        end
        if (pend) begin
          if (cnt <= 1) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(paddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every request and every decode handshake must match the next expectation.
  initial begin
    logic [31:0] a;
    xfer_t       x;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.imem_req) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: addr %h, no request expected", bus.imem_addr);
          end else begin
            a = exp_addr_q.pop_front();
            check("req_addr", bus.imem_addr, a);
          end
        end
        if (bus.id_valid && bus.id_ready) begin
          if (exp_xfer_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: pc %h instr %h, no handoff expected", bus.id_pc, bus.id_instr);
          end else begin
            x = exp_xfer_q.pop_front();
            check("xfer_pc", bus.id_pc, x.pc);
            check("xfer_instr", bus.id_instr, x.instr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
    $fatal(1);
  end

  // Asserts reset for two edges and checks outputs; returns at cycle C1 after release.
  task automatic apply_reset();
    reset = 1'b1;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("req_masked_in_reset", {31'd0, bus.imem_req}, 32'd0);
    step();
    @(negedge clk);
    check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_id_instr", bus.id_instr, 32'h0000_0013);
    check("rst_id_opcode", {25'd0, bus.id_opcode}, 32'h13);
    check("rst_fetch_count", bus.fetch_count, 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'h0000_0000);
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n_req, bad;
    reset = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    bus.id_ready      = 1'b1;

    // 1: basic stream, 1-cycle memory, decode always ready
    lat = 1;
    apply_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_xfer_q.push_back('{32'h0, 32'h0000_0033});
    exp_xfer_q.push_back('{32'h4, 32'h00A0_0093});
    exp_xfer_q.push_back('{32'h8, 32'h0020_8133});
    @(negedge clk);
    check("first_req_after_reset", {31'd0, bus.imem_req}, 32'd1);
    step();
    step();
    @(negedge clk);
    check("s1_id_valid", {31'd0, bus.id_valid}, 32'd1);
    check("s1_id_opcode", {25'd0, bus.id_opcode}, 32'h33);
    step();
    @(negedge clk);
    check("s1_count_after_handshake", bus.fetch_count, 32'd1);
    check("s1_next_addr", bus.imem_addr, 32'h4);
    repeat (6) step();
    check("s1_throughput_count", bus.fetch_count, 32'd3);

    // 2: 4-cycle memory latency, single request pulse
    lat = 4;
    apply_reset();
    exp_addr_q.push_back(32'h0);
    exp_xfer_q.push_back('{32'h0, 32'h0000_0033});
    n_req = 0;
    bad = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.imem_req) n_req++;
      if (i <= 5 && bus.id_valid) bad++;
      if (i == 6) check("s2_valid_after_lat4", {31'd0, bus.id_valid}, 32'd1);
      step();
    end
    check("s2_single_req_pulse", n_req, 32'd1);
    check("s2_no_early_valid", bad, 32'd0);

    // 3: decode stalls 5 cycles in HOLD
    lat = 1;
    apply_reset();
    bus.id_ready = 1'b0;
    exp_addr_q.push_back(32'h0);
    step();
    step();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0000_0033 || bus.imem_req !== 1'b0 ||
          bus.fetch_count !== 32'd0 || bus.id_valid !== 1'b1) bad++;
      step();
    end
    check("s3_hold_stable_cycles_bad", bad, 32'd0);
    bus.id_ready = 1'b1;
    exp_xfer_q.push_back('{32'h0, 32'h0000_0033});
    step();
    check("s3_count_after_release", bus.fetch_count, 32'd1);

    // 4: redirect during WAIT, stale response drained
    lat = 3;
    apply_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h100);
    exp_xfer_q.push_back('{32'h100, 32'h0000_00B3});
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h103;
    bad = 0;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      if (bus.id_valid || bus.imem_req) bad++;
      step();
      bus.branch_taken = 1'b0;
    end
    check("s4_no_valid_or_req_while_draining", bad, 32'd0);
    @(negedge clk);
    check("s4_redirect_addr", bus.imem_addr, 32'h100);
    check("s4_redirect_req", {31'd0, bus.imem_req}, 32'd1);
    repeat (4) step();
    @(negedge clk);
    check("s4_target_word_pc", bus.id_pc, 32'h100);
    step();

    // 5: redirect in HOLD with id_ready high, then redirect in FETCH
    lat = 1;
    apply_reset();
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h300);
    exp_xfer_q.push_back('{32'h300, 32'h0000_0313});
    step();
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    @(negedge clk);
    check("s5_hold_drop_valid", {31'd0, bus.id_valid}, 32'd0);
    step();
    bus.branch_target = 32'h302;
    @(negedge clk);
    check("s5_drop_count", bus.fetch_count, 32'd0);
    check("s5_drop_nop", bus.id_instr, 32'h0000_0013);
    check("s5_fetch_branch_no_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("s5_second_target_addr", bus.imem_addr, 32'h300);
    step();
    step();
    @(negedge clk);
    check("s5_target_pc", bus.id_pc, 32'h300);
    step();
    check("s5_count_after", bus.fetch_count, 32'd1);

    // 6: pc wrap at top of address space, then reset mid-HOLD
    lat = 1;
    apply_reset();
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_xfer_q.push_back('{32'hFFFF_FFFC, 32'hFFFF_FF13});
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFF;
    step();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("s6_aligned_target", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    @(negedge clk);
    check("s6_top_pc", bus.id_pc, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("s6_wrap_addr", bus.imem_addr, 32'h0);
    step();
    step();
    bus.id_ready = 1'b0;
    check("s6_hold_before_reset", {31'd0, bus.id_valid}, 32'd1);
    check("s6_count_before_reset", bus.fetch_count, 32'd1);
    apply_reset();
    reset = 1'b1;
    bus.id_ready = 1'b1;
    step();
    step();

    check("leftover_expected_reqs", exp_addr_q.size(), 32'd0);
    check("leftover_expected_xfers", exp_xfer_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, id_instr value on reset and after a drop.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 branch_taken  input  1  redirect request from execute stage (Branch AND Zero).
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored (forced 0).
REQ-007 imem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-008 imem_addr  output  32  read address, valid while imem_req=1.
REQ-009 imem_rvalid  input  1  read data valid, variable latency >=1 cycle after imem_req.
REQ-010 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-011 id_valid  output  1  instruction available to decode/control stage.
REQ-012 id_ready  input  1  decode/control stage accepts instruction.
REQ-013 id_pc  output  32  PC of the presented instruction.
REQ-014 id_instr  output  32  presented instruction word.
REQ-015 id_opcode  output  7  id_instr[6:0], opcode feeding the control unit.
REQ-016 fetch_count  output  32  count of instructions handed to decode.

Function
REQ-017 FSM states FETCH, WAIT, HOLD, DRAIN; at most one imem request outstanding.
REQ-018 imem_req SHALL be (state==FETCH) AND NOT branch_taken; imem_addr SHALL equal pc.
REQ-019 FETCH, no branch: request issued, next state WAIT.
REQ-020 WAIT, imem_rvalid=1, no branch: id_instr<=imem_rdata, id_pc<=pc, valid_q<=1, pc<=pc+4, next HOLD.
REQ-021 WAIT, imem_rvalid=0: remain WAIT, no output change.
REQ-022 HOLD: id_instr/id_pc stable; on id_ready=1 (no branch) valid_q<=0, fetch_count+=1, next FETCH.
REQ-023 id_valid SHALL be valid_q AND NOT branch_taken (combinational mask); transfer = id_valid AND id_ready.
REQ-024 branch_taken in FETCH: no request issued, pc<=target, stay FETCH.
REQ-025 branch_taken in WAIT with imem_rvalid=0: pc<=target, next DRAIN.
REQ-026 branch_taken in WAIT with imem_rvalid=1: response discarded, pc<=target, next FETCH.
REQ-027 branch_taken in HOLD: held instruction dropped (valid_q<=0, id_instr<=NOP_INSTR), fetch_count unchanged even if id_ready=1, pc<=target, next FETCH.
REQ-028 DRAIN: wait for imem_rvalid, discard data, next FETCH; branch_taken in DRAIN updates pc, stays DRAIN unless rvalid same cycle (then FETCH).
REQ-029 imem_rvalid in FETCH or HOLD SHALL be ignored.
REQ-030 pc+4 and fetch_count SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 Minimum fetch throughput: one instruction per 3 cycles with 1-cycle memory latency and id_ready held high.

Reset
REQ-032 reset=1 SHALL set pc=RESET_PC, state=FETCH, valid_q=0, id_pc=0, id_instr=NOP_INSTR, fetch_count=0, regardless of state.
REQ-033 imem_req SHALL be 0 during reset; reset mid-WAIT abandons the request and the memory is reset on the same reset.
REQ-034 First request SHALL issue in the first cycle after reset deasserts, addr=RESET_PC.

Verification
REQ-035 Reset, 1-cycle memory returning 0x00000033 at 0x0, id_ready=1 -> id_valid high with id_pc=0, id_opcode=7'b0110011; next request addr 0x4; fetch_count=1 after handshake.
REQ-036 Memory latency 4 cycles -> FSM stays WAIT 4 cycles, imem_req single pulse, no duplicate request.
REQ-037 id_ready=0 for 5 cycles in HOLD -> id_instr/id_pc stable, no new imem_req, fetch_count unchanged.
REQ-038 branch_taken target 0x103 during WAIT, rvalid 2 cycles later -> response discarded, next imem_addr=0x100, no id_valid for dropped word.
REQ-039 branch_taken with id_ready=1 in HOLD -> id_valid=0 that cycle, fetch_count unchanged, next fetch at target.
REQ-040 pc=0xFFFFFFFC fetched -> next imem_addr=0x00000000; reset asserted mid-HOLD -> all outputs at reset values next cycle.
